// File: rtl/led_spinner_pkg.sv
// Shared constants, types and helpers for the LED spinner game.
// Step limits are divide counts of the system clock for each selectable step rate.
package led_spinner_pkg;

  localparam int unsigned CLK_FREQ_HZ_DEF     = 32'd50_000_000;
  localparam int unsigned DEFAULT_STEP_HZ_DEF = 32'd1000;

  localparam int PRESC_W = 26;
  localparam int NUM_POS = 6;

  typedef logic [2:0]         pos_t;
  typedef logic [PRESC_W-1:0] presc_t;

  localparam pos_t POS_LAST = 3'd5;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  function automatic presc_t step_limit(input int unsigned freq_hz, input int unsigned step_hz);
    return presc_t'(freq_hz / step_hz);
  endfunction

  localparam presc_t LIM_2HZ     = step_limit(CLK_FREQ_HZ_DEF, 32'd2);
  localparam presc_t LIM_5HZ     = step_limit(CLK_FREQ_HZ_DEF, 32'd5);
  localparam presc_t LIM_10HZ    = step_limit(CLK_FREQ_HZ_DEF, 32'd10);
  localparam presc_t LIM_20HZ    = step_limit(CLK_FREQ_HZ_DEF, 32'd20);
  localparam presc_t LIM_DEFAULT = step_limit(CLK_FREQ_HZ_DEF, DEFAULT_STEP_HZ_DEF);

  // Out-of-range positions fall back to segment a so exactly one segment is ever lit.
  function automatic logic [6:0] seg_encode(input pos_t pos);
    logic [6:0] seg;
    case (pos)
      3'd0:    seg = 7'b000_0001;
      3'd1:    seg = 7'b000_0010;
      3'd2:    seg = 7'b000_0100;
      3'd3:    seg = 7'b000_1000;
      3'd4:    seg = 7'b001_0000;
      3'd5:    seg = 7'b010_0000;
      default: seg = 7'b000_0001;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/led_spinner_tick_gen.sv
// Speed decode and step prescaler: issues a one-cycle tick every L cycles, held at zero while frozen.
module led_spinner_tick_gen
  import led_spinner_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = CLK_FREQ_HZ_DEF,
  parameter int unsigned DEFAULT_STEP_HZ = DEFAULT_STEP_HZ_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] speed,
  input  logic       hold,
  output logic       tick
);

  localparam presc_t L_2HZ  = step_limit(CLK_FREQ_HZ, 32'd2);
  localparam presc_t L_5HZ  = step_limit(CLK_FREQ_HZ, 32'd5);
  localparam presc_t L_10HZ = step_limit(CLK_FREQ_HZ, 32'd10);
  localparam presc_t L_20HZ = step_limit(CLK_FREQ_HZ, 32'd20);
  localparam presc_t L_DEF  = step_limit(CLK_FREQ_HZ, DEFAULT_STEP_HZ);

  presc_t limit_s;
  presc_t prescaler_q;
  presc_t prescaler_d;

  always_comb begin
    case (speed)
      4'b0001: limit_s = L_2HZ;
      4'b0010: limit_s = L_5HZ;
      4'b0100: limit_s = L_10HZ;
      4'b1000: limit_s = L_20HZ;
      default: limit_s = L_DEF;
    endcase
  end

  // The >= compare lets a switch to a shorter period fire immediately instead of wrapping.
  always_comb begin
    prescaler_d = prescaler_q;
    tick        = 1'b0;
    if (hold) begin
      prescaler_d = '0;
      tick        = 1'b0;
    end else if (prescaler_q >= (limit_s - 26'd1)) begin
      prescaler_d = '0;
      tick        = 1'b1;
    end else begin
      prescaler_d = prescaler_q + 26'd1;
      tick        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler_q <= '0;
    end else begin
      prescaler_q <= prescaler_d;
    end
  end

endmodule

// File: rtl/led_spinner_game.sv
// Spinner game top: position register, segment encode and win (decimal point) logic.
// Optional INPUT_SYNC_EN adds 2-flop synchronizers on stop_wheel_in and guess_bits_in.
module led_spinner_game
  import led_spinner_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = CLK_FREQ_HZ_DEF,
  parameter int unsigned DEFAULT_STEP_HZ = DEFAULT_STEP_HZ_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] speed_bits_in,
  input  logic       stop_wheel_in,
  input  logic [5:0] guess_bits_in,
  output logic [6:0] seg_bits_out,
  output logic       dp_on_out
);

  logic       stop_s;
  logic [5:0] guess_s;
  logic       tick_s;
  logic [7:0] guess_ext_s;
  pos_t       pos_q;
  pos_t       pos_d;
  logic [6:0] seg_q;
  logic       dp_q;
  logic       dp_d;

`ifdef INPUT_SYNC_EN
  logic [1:0] stop_sync_q;
  logic [5:0] guess_sync1_q;
  logic [5:0] guess_sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stop_sync_q   <= 2'b00;
      guess_sync1_q <= 6'b00_0000;
      guess_sync2_q <= 6'b00_0000;
    end else begin
      stop_sync_q   <= {stop_sync_q[0], stop_wheel_in};
      guess_sync1_q <= guess_bits_in;
      guess_sync2_q <= guess_sync1_q;
    end
  end

  assign stop_s  = stop_sync_q[1];
  assign guess_s = guess_sync2_q;
`else
  assign stop_s  = stop_wheel_in;
  assign guess_s = guess_bits_in;
`endif

  led_spinner_tick_gen #(
    .CLK_FREQ_HZ     (CLK_FREQ_HZ),
    .DEFAULT_STEP_HZ (DEFAULT_STEP_HZ)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .speed (speed_bits_in),
    .hold  (stop_s),
    .tick  (tick_s)
  );

  // Padding lets an illegal pos index safely; those bits read as "no guess".
  assign guess_ext_s = {2'b00, guess_s};

  always_comb begin
    pos_d = pos_q;
    if (pos_q > POS_LAST) begin
      pos_d = 3'd0;
    end else if (tick_s) begin
      pos_d = (pos_q == POS_LAST) ? 3'd0 : pos_q + 3'd1;
    end else begin
      pos_d = pos_q;
    end
    dp_d = stop_s & guess_ext_s[pos_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q <= 3'd0;
      seg_q <= 7'b000_0001;
      dp_q  <= 1'b0;
    end else begin
      pos_q <= pos_d;
      seg_q <= seg_encode(pos_q);
      dp_q  <= dp_d;
    end
  end

  assign seg_bits_out = seg_q;
  assign dp_on_out    = dp_q;

endmodule

// File: tb/tb_led_spinner_game.sv
// Directed bench for led_spinner_game, run with a scaled clock frequency so that
// step limits are short: default L=10, 2 Hz L=1000, 20 Hz L=100.
module tb_led_spinner_game;

  logic       clk;
  logic       rst_n;
  logic [3:0] speed_bits_in;
  logic       stop_wheel_in;
  logic [5:0] guess_bits_in;
  logic [6:0] seg_bits_out;
  logic       dp_on_out;

  int n_checks;
  int n_errors;

  led_spinner_game #(
    .CLK_FREQ_HZ     (2000),
    .DEFAULT_STEP_HZ (200)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .speed_bits_in (speed_bits_in),
    .stop_wheel_in (stop_wheel_in),
    .guess_bits_in (guess_bits_in),
    .seg_bits_out  (seg_bits_out),
    .dp_on_out     (dp_on_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    speed_bits_in = 4'b0101;
    stop_wheel_in = 1'b0;
    guess_bits_in = 6'b00_0000;
    step(2);
    check_eq("reset_seg", {25'd0, seg_bits_out}, 32'h01);
    check_eq("reset_dp", {31'd0, dp_on_out}, 32'h0);

    // Default speed: pos steps on edge 10, 20, ...; seg follows one edge later.
    rst_n = 1'b1;
    step(10);
    check_eq("def_seg_e10", {25'd0, seg_bits_out}, 32'h01);
    step(1);
    check_eq("def_seg_e11", {25'd0, seg_bits_out}, 32'h02);
    step(10);
    check_eq("def_seg_e21", {25'd0, seg_bits_out}, 32'h04);
    step(39);
    check_eq("def_seg_e60", {25'd0, seg_bits_out}, 32'h20);
    check_eq("def_dp_spin", {31'd0, dp_on_out}, 32'h0);
    step(1);
    check_eq("def_seg_wrap", {25'd0, seg_bits_out}, 32'h01);

    // Stop asserted on the cycle a tick would fire (edge 90): stop wins.
    step(28);
    check_eq("pre_stop_seg", {25'd0, seg_bits_out}, 32'h04);
    stop_wheel_in = 1'b1;
    step(50);
    check_eq("stop_seg_frozen", {25'd0, seg_bits_out}, 32'h04);
    check_eq("stop_dp_noguess", {31'd0, dp_on_out}, 32'h0);

    // Release: first step exactly L=10 edges later.
    stop_wheel_in = 1'b0;
    guess_bits_in = 6'b11_1111;
    step(10);
    check_eq("resume_seg_e10", {25'd0, seg_bits_out}, 32'h04);
    check_eq("resume_dp_spin", {31'd0, dp_on_out}, 32'h0);
    step(1);
    check_eq("resume_seg_e11", {25'd0, seg_bits_out}, 32'h08);

    // Win at pos=3.
    stop_wheel_in = 1'b1;
    step(1);
    check_eq("win_dp", {31'd0, dp_on_out}, 32'h1);
    check_eq("win_seg", {25'd0, seg_bits_out}, 32'h08);
    guess_bits_in = 6'b00_0000;
    step(1);
    check_eq("win_clear_dp", {31'd0, dp_on_out}, 32'h0);
    guess_bits_in = 6'b00_1000;
    step(1);
    check_eq("win_onebit_dp", {31'd0, dp_on_out}, 32'h1);
    guess_bits_in = 6'b00_0100;
    step(1);
    check_eq("win_wrongbit_dp", {31'd0, dp_on_out}, 32'h0);

    // 2 Hz speed: L=1000 from release.
    guess_bits_in = 6'b00_1000;
    speed_bits_in = 4'b0001;
    stop_wheel_in = 1'b0;
    step(1);
    check_eq("spin_dp_guess", {31'd0, dp_on_out}, 32'h0);
    step(999);
    check_eq("slow_seg_e1000", {25'd0, seg_bits_out}, 32'h08);
    step(1);
    check_eq("slow_seg_e1001", {25'd0, seg_bits_out}, 32'h10);

    // Prescaler is 201 here; switching to L=100 ticks on the next edge.
    step(200);
    speed_bits_in = 4'b1000;
    step(1);
    check_eq("fast_switch_e1", {25'd0, seg_bits_out}, 32'h10);
    step(1);
    check_eq("fast_switch_e2", {25'd0, seg_bits_out}, 32'h20);
    step(500);
    check_eq("fast_seg_pos4", {25'd0, seg_bits_out}, 32'h10);

    // Reset overrides stop with a matching guess.
    rst_n         = 1'b0;
    stop_wheel_in = 1'b1;
    guess_bits_in = 6'b11_1111;
    step(1);
    check_eq("midrst_seg", {25'd0, seg_bits_out}, 32'h01);
    check_eq("midrst_dp", {31'd0, dp_on_out}, 32'h0);
    rst_n         = 1'b1;
    stop_wheel_in = 1'b0;
    step(100);
    check_eq("postrst_seg_e100", {25'd0, seg_bits_out}, 32'h01);
    step(1);
    check_eq("postrst_seg_e101", {25'd0, seg_bits_out}, 32'h02);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
